// File: rtl/timer_pkg.sv
// Shared types and constants for the interval timer controller and its counting core.
package timer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic MODE_ONESHOT  = 1'b0;
  localparam logic MODE_PERIODIC = 1'b1;

  localparam int DEF_WIDTH   = 4;
  localparam int DEF_PRESC_W = 4;

endpackage

// File: rtl/interval_timer_ctrl_count_core.sv
// WIDTH-bit up-counter with synchronous clear (priority over enable) and async reset.
module count_core
  import timer_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  output logic [WIDTH-1:0] count
);

  localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] count_r;

  // Count register: clear wins over enable, wraps modulo 2^WIDTH.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_r <= ZERO;
    end else if (clear) begin
      count_r <= ZERO;
    end else if (enable) begin
      count_r <= count_r + ONE;
    end else begin
      count_r <= count_r;
    end
  end

  assign count = count_r;

endmodule

// File: rtl/interval_timer_ctrl.sv
// Interval timer controller: sequences count_core through IDLE/RUN/DONE.
// Optional step prescaler is built when TIMER_PRESCALE_EN is defined.
module interval_timer_ctrl
  import timer_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH
`ifdef TIMER_PRESCALE_EN
  , parameter int PRESC_W = DEF_PRESC_W
`endif
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               stop,
  input  logic               hold,
  input  logic               mode,
  input  logic [WIDTH-1:0]   limit,
`ifdef TIMER_PRESCALE_EN
  input  logic [PRESC_W-1:0] presc,
`endif
  output logic [WIDTH-1:0]   count,
  output logic               busy,
  output logic               tick,
  output logic               done
);

  state_t           state_r, state_s;
  logic [WIDTH-1:0] limit_r;
  logic             mode_r;
  logic             tick_r, busy_r, done_r;
  logic             clear_s, enable_s, tick_s, capture_s;
  logic             step_s, presc_ok_s, at_lim_s;
  logic [WIDTH-1:0] count_s;

  count_core #(.WIDTH(WIDTH)) u_core (
    .clk    (clk),
    .reset  (reset),
    .clear  (clear_s),
    .enable (enable_s),
    .count  (count_s)
  );

`ifdef TIMER_PRESCALE_EN
  localparam logic [PRESC_W-1:0] P_ZERO = {PRESC_W{1'b0}};
  localparam logic [PRESC_W-1:0] P_ONE  = {{(PRESC_W-1){1'b0}}, 1'b1};

  logic [PRESC_W-1:0] presc_r, p_r;

  // Prescaler: p runs 0..presc_r while counting; frozen by hold.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc_r <= P_ZERO;
      p_r     <= P_ZERO;
    end else if (capture_s) begin
      presc_r <= presc;
      p_r     <= P_ZERO;
    end else if (stop) begin
      p_r <= P_ZERO;
    end else if ((state_r == RUN) && !hold) begin
      p_r <= (p_r == presc_r) ? P_ZERO : (p_r + P_ONE);
    end else begin
      p_r <= p_r;
    end
  end

  assign presc_ok_s = (p_r == presc_r);
`else
  assign presc_ok_s = 1'b1;
`endif

  assign step_s   = (state_r == RUN) && !hold && presc_ok_s;
  assign at_lim_s = (count_s == limit_r);

  // Next-state and core control; stop dominates every other request.
  always_comb begin
    state_s   = state_r;
    clear_s   = 1'b0;
    enable_s  = 1'b0;
    tick_s    = 1'b0;
    capture_s = 1'b0;
    if (stop) begin
      state_s = IDLE;
      clear_s = 1'b1;
    end else begin
      case (state_r)
        IDLE, DONE: begin
          if (start) begin
            capture_s = 1'b1;
            clear_s   = 1'b1;
            state_s   = RUN;
          end else begin
            state_s = state_r;
          end
        end
        RUN: begin
          if (step_s && at_lim_s) begin
            tick_s = 1'b1;
            if (mode_r == MODE_PERIODIC) begin
              clear_s = 1'b1;
            end else begin
              state_s = DONE;
            end
          end else if (step_s) begin
            enable_s = 1'b1;
          end else begin
            enable_s = 1'b0;
          end
        end
        default: begin
          state_s = IDLE;
          clear_s = 1'b1;
        end
      endcase
    end
  end

  // Control registers; busy/done are registered from the next state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
      limit_r <= {WIDTH{1'b0}};
      mode_r  <= MODE_ONESHOT;
      tick_r  <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      tick_r  <= tick_s;
      busy_r  <= (state_s == RUN);
      done_r  <= (state_s == DONE);
      if (capture_s) begin
        limit_r <= limit;
        mode_r  <= mode;
      end else begin
        limit_r <= limit_r;
        mode_r  <= mode_r;
      end
    end
  end

  assign count = count_s;
  assign busy  = busy_r;
  assign tick  = tick_r;
  assign done  = done_r;

endmodule

// File: tb/tb_interval_timer_ctrl.sv
// Scoreboard bench for interval_timer_ctrl (WIDTH=4); prescaler scenario when TIMER_PRESCALE_EN.
module tb_interval_timer_ctrl;

  logic       clk = 1'b0;
  logic       reset, start, stop, hold, mode;
  logic [3:0] limit;
`ifdef TIMER_PRESCALE_EN
  logic [3:0] presc;
`endif
  logic [3:0] count;
  logic       busy, tick, done;

  int         vec_cnt = 0;
  int         err_cnt = 0;
  logic [6:0] exp_q[$];

  interval_timer_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .stop  (stop),
    .hold  (hold),
    .mode  (mode),
    .limit (limit),
`ifdef TIMER_PRESCALE_EN
    .presc (presc),
`endif
    .count (count),
    .busy  (busy),
    .tick  (tick),
    .done  (done)
  );

  always #5 clk = ~clk;

  task automatic check_vec(input string tag, input logic [6:0] obs, input logic [6:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s @%0t: got count=%0d busy=%b tick=%b done=%b, want count=%0d busy=%b tick=%b done=%b",
               tag, $time, obs[6:3], obs[2], obs[1], obs[0], exp[6:3], exp[2], exp[1], exp[0]);
    end
  endtask

  task automatic pop_check(input string tag);
    logic [6:0] e;
    e = exp_q.pop_front();
    check_vec(tag, {count, busy, tick, done}, e);
  endtask

  // Expect an output state after the next rising edge
  task automatic cyc(input string tag, input int c, input logic b, input logic t, input logic d);
    exp_q.push_back({4'(c), b, t, d});
    @(posedge clk);
    #1;
    pop_check(tag);
  endtask

  // Expect an output state right now, without a clock edge
  task automatic now_chk(input string tag, input int c, input logic b, input logic t, input logic d);
    exp_q.push_back({4'(c), b, t, d});
    pop_check(tag);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; stop = 1'b0; hold = 1'b0; mode = 1'b0; limit = 4'd0;
`ifdef TIMER_PRESCALE_EN
    presc = 4'd0;
`endif
    #12;
    now_chk("reset", 0, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    reset = 1'b0;

    // One-shot, limit 5
    start = 1'b1; mode = 1'b0; limit = 4'd5;
    cyc("os_start", 0, 1'b1, 1'b0, 1'b0);
    start = 1'b0; limit = 4'd0;
    for (int k = 1; k <= 5; k++) cyc("os_count", k, 1'b1, 1'b0, 1'b0);
    cyc("os_tick", 5, 1'b0, 1'b1, 1'b1);
    cyc("os_done_hold", 5, 1'b0, 1'b0, 1'b1);
    stop = 1'b1;
    cyc("os_stop", 0, 1'b0, 1'b0, 1'b0);
    stop = 1'b0;

    // Periodic, limit 3, 12 cycles
    start = 1'b1; mode = 1'b1; limit = 4'd3;
    cyc("per3_start", 0, 1'b1, 1'b0, 1'b0);
    start = 1'b0;
    for (int e = 1; e <= 12; e++) cyc("per3", e % 4, 1'b1, (e % 4) == 0, 1'b0);
    stop = 1'b1;
    cyc("per3_stop", 0, 1'b0, 1'b0, 1'b0);
    stop = 1'b0;

    // Periodic, full range
    start = 1'b1; mode = 1'b1; limit = 4'd15;
    cyc("per15_start", 0, 1'b1, 1'b0, 1'b0);
    start = 1'b0;
    for (int e = 1; e <= 18; e++) cyc("per15", e % 16, 1'b1, e == 16, 1'b0);
    stop = 1'b1;
    cyc("per15_stop", 0, 1'b0, 1'b0, 1'b0);
    stop = 1'b0;

    // Hold at count 2, then stop+start together at terminal count
    start = 1'b1; mode = 1'b1; limit = 4'd3;
    cyc("hold_start", 0, 1'b1, 1'b0, 1'b0);
    start = 1'b0;
    cyc("hold_c1", 1, 1'b1, 1'b0, 1'b0);
    cyc("hold_c2", 2, 1'b1, 1'b0, 1'b0);
    hold = 1'b1;
    for (int k = 0; k < 3; k++) cyc("hold_frozen", 2, 1'b1, 1'b0, 1'b0);
    hold = 1'b0;
    cyc("hold_c3", 3, 1'b1, 1'b0, 1'b0);
    cyc("hold_tick", 0, 1'b1, 1'b1, 1'b0);
    for (int k = 1; k <= 3; k++) cyc("hold_run", k, 1'b1, 1'b0, 1'b0);
    stop = 1'b1; start = 1'b1;
    cyc("stop_over_start", 0, 1'b0, 1'b0, 1'b0);
    stop = 1'b0; start = 1'b0;
    cyc("stop_idle", 0, 1'b0, 1'b0, 1'b0);

    // Async reset mid-run at count 7, then a fresh one-shot
    start = 1'b1; mode = 1'b1; limit = 4'd15;
    cyc("rst_start", 0, 1'b1, 1'b0, 1'b0);
    start = 1'b0;
    for (int k = 1; k <= 7; k++) cyc("rst_run", k, 1'b1, 1'b0, 1'b0);
    #2 reset = 1'b1;
    #1 now_chk("async_reset", 0, 1'b0, 1'b0, 1'b0);
    #1 reset = 1'b0;
    start = 1'b1; mode = 1'b0; limit = 4'd2;
    cyc("post_rst_start", 0, 1'b1, 1'b0, 1'b0);
    start = 1'b0;
    cyc("post_rst_c1", 1, 1'b1, 1'b0, 1'b0);
    cyc("post_rst_c2", 2, 1'b1, 1'b0, 1'b0);
    cyc("post_rst_done", 2, 1'b0, 1'b1, 1'b1);

    // Limit 0: one-shot ends at first step; restart from DONE as periodic
    start = 1'b1; mode = 1'b0; limit = 4'd0;
    cyc("lim0_os_start", 0, 1'b1, 1'b0, 1'b0);
    start = 1'b0;
    cyc("lim0_os_done", 0, 1'b0, 1'b1, 1'b1);
    start = 1'b1; mode = 1'b1; limit = 4'd0;
    cyc("lim0_per_start", 0, 1'b1, 1'b0, 1'b0);
    limit = 4'd9;
    cyc("start_in_run_ignored", 0, 1'b1, 1'b1, 1'b0);
    start = 1'b0;
    cyc("lim0_per_a", 0, 1'b1, 1'b1, 1'b0);
    cyc("lim0_per_b", 0, 1'b1, 1'b1, 1'b0);
    stop = 1'b1;
    cyc("lim0_stop", 0, 1'b0, 1'b0, 1'b0);
    stop = 1'b0;

`ifdef TIMER_PRESCALE_EN
    // Prescale by 3, one-shot limit 2
    start = 1'b1; mode = 1'b0; limit = 4'd2; presc = 4'd2;
    cyc("presc_start", 0, 1'b1, 1'b0, 1'b0);
    start = 1'b0; presc = 4'd0;
    for (int e = 1; e <= 9; e++) begin
      if (e == 9) cyc("presc_done", 2, 1'b0, 1'b1, 1'b1);
      else        cyc("presc_run", e / 3, 1'b1, 1'b0, 1'b0);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/interval_timer_ctrl.md
# interval_timer_ctrl

Controller that sequences a free-running up-count datapath into a programmable interval timer. It accepts start/stop/hold commands, runs the counter up to a captured limit, and produces a terminal-count tick in one-shot or periodic mode. It sits between software-style control strobes and the counting core, and is the only agent allowed to clear or enable that core.

## Interface
- WIDTH, 4, count and limit width
- PRESC_W, 4, prescaler width (used only with TIMER_PRESCALE_EN)

- clk  in  1  clock, rising-edge
- reset  in  1  asynchronous, active-high
- start  in  1  single-cycle request to begin a run
- stop  in  1  abort run, return to IDLE
- hold  in  1  level; freezes counting while RUN
- mode  in  1  0 = one-shot, 1 = periodic; sampled with start
- limit  in  WIDTH  terminal count; sampled with start
- presc  in  PRESC_W  step divider; present only with TIMER_PRESCALE_EN; sampled with start
- count  out  WIDTH  current count
- busy  out  1  high in RUN
- tick  out  1  one-cycle pulse per terminal count
- done  out  1  high in DONE (one-shot finished)

## Operation
- States: IDLE, RUN, DONE. Reset → IDLE; count=0, busy=0, tick=0, done=0.
- IDLE/DONE + start (stop low): capture limit, mode, presc; count←0; → RUN.
- RUN: start ignored. A "step" occurs each cycle hold=0 and the prescaler is satisfied.
- Step with count≠limit_q: count←count+1 (modulo 2^WIDTH).
- Step with count==limit_q: tick←1 for one cycle; periodic: count←0, stay RUN; one-shot: count holds limit_q, → DONE.
- DONE: count frozen, done=1 until start (→ RUN) or stop (→ IDLE, count←0).
- stop in any state: → IDLE, count←0; stop overrides start and suppresses a coincident tick.
- limit_q=0: periodic ticks every step with count stuck at 0; one-shot ends at first step.
- limit_q=2^WIDTH−1: full range, no premature wrap; terminal behaviour as above.
- hold=1: count, prescaler and state frozen; stop still honoured.

## Timing
- All outputs registered; no combinational input→output path.
- start sampled at edge 0 → busy=1, count=0 after edge 0; count=k after edge k (no hold, no prescale).
- One-shot, limit L: count=L after edge L; after edge L+1 tick=1, done=1, busy=0.
- Periodic: tick period L+1 steps; tick and count=0 become visible after the same edge.
- Reset asserted mid-run: all outputs 0 immediately, independent of clk.

## Configuration
- TIMER_PRESCALE_EN defined: presc port exists; internal counter p runs 0..presc_q, step only when p==presc_q (then p←0); p←0 on start and stop; presc=0 means step every cycle.
- Undefined: no presc port, no prescaler logic; step every cycle hold=0.

## Structure
- Shared package timer_pkg: state enum (IDLE, RUN, DONE), mode encodings (MODE_ONESHOT, MODE_PERIODIC), default WIDTH/PRESC_W constants.
- One sub-module, count_core: WIDTH-bit up-counter with synchronous clear and enable, async reset; the controller drives clear/enable and compares its output against limit_q.

## Test plan
- WIDTH=4, mode=0, limit=5, start → count 1..5 on edges 1..5, tick and done high after edge 6, busy low, count holds 5.
- mode=1, limit=3, run 12 cycles → tick after edges 4, 8, 12; count sequence 0,1,2,3,0,...
- limit=15, mode=1 → count reaches 15, tick, wraps to 0; no tick at any other value.
- hold high for 3 cycles at count=2 → count stays 2, then tick delayed by exactly 3 cycles; stop and start asserted together at terminal count → IDLE, count=0, no tick.
- reset asserted asynchronously mid-run at count=7 → count=0, busy=0, done=0 before next clk edge; start afterwards behaves as from power-up.
- TIMER_PRESCALE_EN, presc=2, limit=2, mode=0 → count increments every 3rd cycle; done after 9 cycles.
